// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg
//   Shared constants for the MIPS execute unit: funct codes and the
//   multiply/divide sequencer state encoding.
//   The variable-shift codes (SLLV/SRLV/SRAV) are only decoded when the
//   design is built with MIPS_ALU_SHIFT_EN defined.
package mips_alu_pkg;

   localparam logic [5:0] F_SLLV  = 6'h04;
   localparam logic [5:0] F_SRLV  = 6'h06;
   localparam logic [5:0] F_SRAV  = 6'h07;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_XOR   = 6'h26;
   localparam logic [5:0] F_NOR   = 6'h27;
   localparam logic [5:0] F_SLT   = 6'h2A;
   localparam logic [5:0] F_SLTU  = 6'h2B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/mips_muldiv_seq.sv
// mips_muldiv_seq
//   Iterative multiply / divide engine: radix-2 shift-add multiply and
//   restoring divide, one bit per clock, followed by a sign fix-up cycle.
//   Ports:
//     clk, reset_n       clock, synchronous active-low reset (aborts any op)
//     start              begin an operation (honoured only when idle)
//     is_div, is_signed  operation select, latched at start
//     a, b               operands (dividend/multiplicand in a, divisor in b)
//     busy               high from the start edge until DONE has retired
//     done               high for the single DONE cycle; res is valid then
//     was_div            the retiring operation was a divide
//     div_by_zero        the retiring divide had divisor 0
//     res                {HI,LO}: product, or {remainder,quotient}
module mips_muldiv_seq
   import mips_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               is_div,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic               was_div,
   output logic               div_by_zero,
   output logic [2*WIDTH-1:0] res
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_e             state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [2*WIDTH-1:0] acc_reg;    // {partial product | remainder, multiplier | quotient}
   logic [WIDTH-1:0]   opb_reg;    // multiplicand or divisor magnitude
   logic               neg_q_reg;  // product / quotient must be negated
   logic               neg_r_reg;  // remainder must be negated
   logic               dz_reg;
   logic               op_div_reg;
   logic               busy_reg;
   logic               done_reg;

   // Operand magnitudes; unsigned ops pass straight through.
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign a_neg = is_signed & a[WIDTH-1];
   assign b_neg = is_signed & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   // Multiply step: add multiplicand into the upper half when the current
   // multiplier bit is set, then shift the whole accumulator right with carry.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_reg[0] ? opb_reg : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

   // Restoring divide step: shift the next dividend bit into the remainder,
   // subtract the divisor if it fits and record the quotient bit.
   logic [WIDTH:0]     div_t;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;

   assign div_t    = acc_reg[2*WIDTH-1:WIDTH-1];
   assign div_ge   = (div_t >= {1'b0, opb_reg});
   assign div_rem  = div_ge ? WIDTH'(div_t - {1'b0, opb_reg}) : div_t[WIDTH-1:0];
   assign div_next = {div_rem, acc_reg[WIDTH-2:0], div_ge};

   // Sign fix-up, evaluated from the settled accumulator during DONE.
   logic [WIDTH-1:0] q_raw, r_raw, q_fix, r_fix;

   assign q_raw = acc_reg[WIDTH-1:0];
   assign r_raw = acc_reg[2*WIDTH-1:WIDTH];
   // A zero divisor yields all-ones regardless of sign; the remainder path
   // already reproduces the original dividend.
   assign q_fix = dz_reg ? {WIDTH{1'b1}} : (neg_q_reg ? -q_raw : q_raw);
   assign r_fix = neg_r_reg ? -r_raw : r_raw;
   assign res   = op_div_reg ? {r_fix, q_fix} : (neg_q_reg ? -acc_reg : acc_reg);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         acc_reg    <= '0;
         opb_reg    <= '0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         dz_reg     <= 1'b0;
         op_div_reg <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  acc_reg    <= {{WIDTH{1'b0}}, a_mag};
                  opb_reg    <= b_mag;
                  neg_q_reg  <= a_neg ^ b_neg;
                  neg_r_reg  <= a_neg;
                  dz_reg     <= is_div & (b == '0);
                  op_div_reg <= is_div;
                  cnt_reg    <= CNT_W'(WIDTH);
                  busy_reg   <= 1'b1;
                  state_reg  <= is_div ? DIV : MUL;
               end
            end
            MUL: begin
               acc_reg <= mul_next;
               cnt_reg <= cnt_reg - CNT_W'(1);
               if (cnt_reg == CNT_W'(1)) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end
            end
            DIV: begin
               acc_reg <= div_next;
               cnt_reg <= cnt_reg - CNT_W'(1);
               if (cnt_reg == CNT_W'(1)) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end
            end
            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign was_div     = op_div_reg;
   assign div_by_zero = dz_reg;

endmodule

// File: rtl/mips_muldiv_alu.sv
// mips_muldiv_alu
//   MIPS EX-stage unit: single-cycle R-type ALU ops selected by funct, plus
//   multi-cycle MULT/MULTU/DIV/DIVU writing HI/LO through mips_muldiv_seq.
//   Build option: define MIPS_ALU_SHIFT_EN to decode SLLV/SRLV/SRAV;
//   otherwise those funct codes report illegal.
//   Ports:
//     clk, reset_n         clock, synchronous active-low reset
//     in_valid / in_ready  request handshake; in_ready low while mul/div busy
//     funct, a, b          funct code and rs/rt operands
//     out_valid            one-cycle result pulse
//     result, zero         result (held between pulses) and its NOR reduction
//     ovf, cout            signed overflow and carry/borrow of add/sub
//     div0                 last completed divide had a zero divisor
//     illegal              unknown funct, pulses with out_valid
//     busy                 mul/div in progress
//     hi, lo               HI/LO registers
module mips_muldiv_alu
   import mips_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf,
   output logic             cout,
   output logic             div0,
   output logic             illegal,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

`ifdef MIPS_ALU_SHIFT_EN
   localparam int SH_W = $clog2(WIDTH);
`endif

   logic             out_valid_reg;
   logic [WIDTH-1:0] result_reg;
   logic             ovf_reg;
   logic             cout_reg;
   logic             div0_reg;
   logic             illegal_reg;
   logic [WIDTH-1:0] hi_reg;
   logic [WIDTH-1:0] lo_reg;

   logic               md_busy, md_done, md_was_div, md_dz;
   logic [2*WIDTH-1:0] md_res;

   logic accept;
   assign in_ready = ~md_busy;
   assign accept   = in_valid & in_ready;

   // Carry/borrow taken from the extra top bit of a widened add/subtract.
   logic [WIDTH:0] add_sum, sub_diff;
   logic           add_ovf, sub_ovf;

   assign add_sum  = {1'b0, a} + {1'b0, b};
   assign sub_diff = {1'b0, a} - {1'b0, b};
   assign add_ovf  = (a[WIDTH-1] & b[WIDTH-1] & ~add_sum[WIDTH-1])
                   | (~a[WIDTH-1] & ~b[WIDTH-1] & add_sum[WIDTH-1]);
   assign sub_ovf  = (a[WIDTH-1] & ~b[WIDTH-1] & ~sub_diff[WIDTH-1])
                   | (~a[WIDTH-1] & b[WIDTH-1] & sub_diff[WIDTH-1]);

   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf, alu_cout, alu_ill;
   logic             is_md, md_div, md_signed;

   always_comb begin
      alu_res   = '0;
      alu_ovf   = 1'b0;
      alu_cout  = 1'b0;
      alu_ill   = 1'b0;
      is_md     = 1'b0;
      md_div    = 1'b0;
      md_signed = 1'b0;
      case (funct)
         F_ADD:  begin alu_res = add_sum[WIDTH-1:0];  alu_cout = add_sum[WIDTH];  alu_ovf = add_ovf; end
         F_ADDU: begin alu_res = add_sum[WIDTH-1:0];  alu_cout = add_sum[WIDTH];  end
         F_SUB:  begin alu_res = sub_diff[WIDTH-1:0]; alu_cout = sub_diff[WIDTH]; alu_ovf = sub_ovf; end
         F_SUBU: begin alu_res = sub_diff[WIDTH-1:0]; alu_cout = sub_diff[WIDTH]; end
         F_AND:  alu_res = a & b;
         F_OR:   alu_res = a | b;
         F_XOR:  alu_res = a ^ b;
         F_NOR:  alu_res = ~(a | b);
         F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         F_MFHI: alu_res = hi_reg;
         F_MFLO: alu_res = lo_reg;
         F_MULT:  begin is_md = 1'b1; md_signed = 1'b1; end
         F_MULTU: begin is_md = 1'b1; end
         F_DIV:   begin is_md = 1'b1; md_div = 1'b1; md_signed = 1'b1; end
         F_DIVU:  begin is_md = 1'b1; md_div = 1'b1; end
`ifdef MIPS_ALU_SHIFT_EN
         F_SLLV: alu_res = b << a[SH_W-1:0];
         F_SRLV: alu_res = b >> a[SH_W-1:0];
         F_SRAV: alu_res = WIDTH'($signed(b) >>> a[SH_W-1:0]);
`endif
         default: alu_ill = 1'b1;
      endcase
   end

   mips_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (accept & is_md),
      .is_div      (md_div),
      .is_signed   (md_signed),
      .a           (a),
      .b           (b),
      .busy        (md_busy),
      .done        (md_done),
      .was_div     (md_was_div),
      .div_by_zero (md_dz),
      .res         (md_res)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         ovf_reg       <= 1'b0;
         cout_reg      <= 1'b0;
         div0_reg      <= 1'b0;
         illegal_reg   <= 1'b0;
         hi_reg        <= '0;
         lo_reg        <= '0;
      end else begin
         out_valid_reg <= 1'b0;
         illegal_reg   <= 1'b0;
         // A single-cycle accept and a mul/div retirement never coincide:
         // in_ready is low for the whole mul/div including DONE.
         if (accept && !is_md) begin
            out_valid_reg <= 1'b1;
            result_reg    <= alu_res;
            ovf_reg       <= alu_ovf;
            cout_reg      <= alu_cout;
            illegal_reg   <= alu_ill;
         end
         if (md_done) begin
            out_valid_reg <= 1'b1;
            result_reg    <= md_res[WIDTH-1:0];
            ovf_reg       <= 1'b0;
            cout_reg      <= 1'b0;
            hi_reg        <= md_res[2*WIDTH-1:WIDTH];
            lo_reg        <= md_res[WIDTH-1:0];
            if (md_was_div) begin
               div0_reg <= md_dz;
            end
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign zero      = ~|result_reg;
   assign ovf       = ovf_reg;
   assign cout      = cout_reg;
   assign div0      = div0_reg;
   assign illegal   = illegal_reg;
   assign busy      = md_busy;
   assign hi        = hi_reg;
   assign lo        = lo_reg;

endmodule

// File: tb/tb_mips_muldiv_alu.sv
// tb_mips_muldiv_alu
//   Directed, table-driven bench for mips_muldiv_alu (WIDTH=32): a vector
//   table of single-cycle ops issued back-to-back, then hand-written
//   sequences for multiply, divide, divide-by-zero and mid-operation reset.
module tb_mips_muldiv_alu;
   import mips_alu_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [5:0]    funct;
   logic [W-1:0]  a, b;
   logic          out_valid;
   logic [W-1:0]  result;
   logic          zero, ovf, cout, div0, illegal, busy;
   logic [W-1:0]  hi, lo;

   int total = 0;
   int bad   = 0;

   mips_muldiv_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .funct     (funct),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .result    (result),
      .zero      (zero),
      .ovf       (ovf),
      .cout      (cout),
      .div0      (div0),
      .illegal   (illegal),
      .busy      (busy),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [5:0]  f;
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] res;
      logic        ovf;
      logic        cout;
      logic        ill;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one mul/div, optionally holding an ADD request during busy, and
   // check timing, HI/LO and div0 at retirement.
   task automatic run_md(input string name, input logic [5:0] f,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic exp_dz, input bit hold_add);
      int got;
      int flag_err;
      got = 0;
      flag_err = 0;
      @(negedge clk);
      funct = f; a = va; b = vb; in_valid = 1'b1;
      chk({name, "_ready"}, {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      if (hold_add) begin
         funct = F_ADD; a = 32'd1; b = 32'd2;
      end else begin
         in_valid = 1'b0;
      end
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            got = c;
            break;
         end
         if (busy !== 1'b1 || in_ready !== 1'b0) flag_err++;
      end
      chk({name, "_busy_window"}, 64'(flag_err), 64'd0);
      chk({name, "_latency"}, 64'(got), 64'(W + 1));
      chk({name, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
      chk({name, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
      chk({name, "_result"}, {32'd0, result}, {32'd0, exp_lo});
      chk({name, "_flags"}, {61'd0, illegal, ovf, div0}, {61'd0, 1'b0, 1'b0, exp_dz});
      $display("md %s a=%h b=%h hi=%h lo=%h div0=%b", name, va, vb, hi, lo, div0);
      if (hold_add) begin
         got = 0;
         for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
               got = c;
               break;
            end
         end
         @(negedge clk);
         in_valid = 1'b0;
         chk({name, "_held_add_seen"}, {63'd0, (got != 0)}, 64'd1);
         chk({name, "_held_add_res"}, {32'd0, result}, 64'd3);
      end
   endtask

   initial begin
      vecs[0]  = '{"add_ovf",  F_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{"subu_eq",  F_SUBU, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{"addu_wrap",F_ADDU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{"sub_brw",  F_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{"sub_ovf",  F_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{"and",      F_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{"or",       F_OR,   32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{"xor",      F_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{"nor",      F_NOR,  32'h0000FFFF, 32'h00FF0000, 32'hFF000000, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{"slt",      F_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{"sltu",     F_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{"ill_3f",   6'h3F,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b1};
`ifdef MIPS_ALU_SHIFT_EN
      vecs[12] = '{"srav",     F_SRAV, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{"sllv",     F_SLLV, 32'h00000024, 32'h00000001, 32'h00000010, 1'b0, 1'b0, 1'b0};
`else
      vecs[12] = '{"srav_ill", F_SRAV, 32'h00000004, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{"sllv_ill", F_SLLV, 32'h00000024, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1};
`endif

      reset_n = 1'b0; in_valid = 1'b0; funct = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_outs", {57'd0, out_valid, busy, div0, illegal, ovf, cout, zero},
          {57'd0, 7'b0000001});
      chk("rst_result", {32'd0, result}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      $display("reset in_ready=%b busy=%b hi=%h lo=%h", in_ready, busy, hi, lo);

      // Single-cycle table, issued back-to-back every cycle.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         funct = vecs[i].f; a = vecs[i].va; b = vecs[i].vb; in_valid = 1'b1;
         @(posedge clk); #1;
         chk({vecs[i].name, "_valid"},   {63'd0, out_valid}, 64'd1);
         chk({vecs[i].name, "_result"},  {32'd0, result}, {32'd0, vecs[i].res});
         chk({vecs[i].name, "_ovf"},     {63'd0, ovf}, {63'd0, vecs[i].ovf});
         chk({vecs[i].name, "_cout"},    {63'd0, cout}, {63'd0, vecs[i].cout});
         chk({vecs[i].name, "_zero"},    {63'd0, zero}, {63'd0, (vecs[i].res == 32'd0)});
         chk({vecs[i].name, "_illegal"}, {63'd0, illegal}, {63'd0, vecs[i].ill});
         $display("op %s a=%h b=%h result=%h ovf=%b cout=%b ill=%b",
                  vecs[i].name, vecs[i].va, vecs[i].vb, result, ovf, cout, illegal);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("valid_drops", {63'd0, out_valid}, 64'd0);

      run_md("mult_neg", F_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1);

      @(negedge clk);
      funct = F_MFHI; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("mfhi_valid", {63'd0, out_valid}, 64'd1);
      chk("mfhi_result", {32'd0, result}, 64'hFFFFFFFF);
      $display("op mfhi result=%h", result);
      @(negedge clk);
      in_valid = 1'b0;

      run_md("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
      run_md("div_m7_2", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
      run_md("div_min_m1", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1'b0);
      run_md("divu_5_0", F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1'b0);
      run_md("divu_6_3", F_DIVU, 32'd6, 32'd3, 32'd0, 32'd2, 1'b0, 1'b0);
      run_md("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);

      // Reset in the middle of a MULTU: no completion, HI/LO cleared.
      @(negedge clk);
      funct = F_MULTU; a = 32'd3; b = 32'd5; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("mrst_no_valid", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("mrst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("mrst_busy", {63'd0, busy}, 64'd0);
      chk("mrst_hilo", {hi, lo}, 64'd0);
      begin
         int seen;
         seen = 0;
         for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
         end
         chk("mrst_no_late_valid", 64'(seen), 64'd0);
      end
      $display("midreset in_ready=%b hi=%h lo=%h", in_ready, hi, lo);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
